// File: rtl/cipu_pkg.sv
//------------------------------------------------------------------------------
// Module   : cipu_pkg
// Purpose  : Shared state, readback-select and ASCII constants for the collector.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cipu_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DONE    = 2'd1
  } state_e;

  localparam logic [1:0] SEL_PEOPLE = 2'd0;
  localparam logic [1:0] SEL_LIFO   = 2'd1;
  localparam logic [1:0] SEL_FIFO2  = 2'd2;
  localparam logic [1:0] SEL_GROUP  = 2'd3;

  localparam logic [7:0] CHR_A = 8'h41;
  localparam logic [7:0] CHR_Z = 8'h5A;
  localparam logic [7:0] CHR_0 = 8'h30;
  localparam logic [7:0] CHR_9 = 8'h39;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= CHR_A) && (c <= CHR_Z);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CHR_0) && (c <= CHR_9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cipu_byte_buf.sv
//------------------------------------------------------------------------------
// Module   : cipu_byte_buf
// Purpose  : Append-only byte buffer with saturating count and bounded async read.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cipu_byte_buf
  import cipu_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic [AW:0]   cnt_o,
  output logic          ovf_o
);

  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE  = (AW+1)'(1);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] cnt_q, cnt_d;
  logic        full;
  logic        wr_en;

  assign full  = (cnt_q == C_FULL);
  assign wr_en = we_i & ~full & ~clr_i;
  assign ovf_o = we_i & full & ~clr_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wr_en) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Storage is never reset; the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[cnt_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rd_data_o = ({1'b0, rd_addr_i} < cnt_q) ? mem_q[rd_addr_i] : 8'h00;
  assign cnt_o     = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cipu_out_collector.sv
//------------------------------------------------------------------------------
// Module   : cipu_out_collector
// Purpose  : Captures people/LIFO/FIFO2 output streams and group boundaries of
//            the check-in/pickup unit, freezes them on completion for readback.
//            Optional character checking enabled by CIPU_COLLECT_CHK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cipu_out_collector
  import cipu_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int GDEPTH = 16,
  parameter int GAW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_fifo,
  input  logic          valid_lifo,
  input  logic          valid_fifo2,
  input  logic [7:0]    people_thing_out,
  input  logic [7:0]    thing_out,
  input  logic          done_thing,
  input  logic          done_fifo,
  input  logic          done_lifo,
  input  logic          done_fifo2,
  input  logic          clear,
  input  logic [1:0]    rd_sel,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW:0]   people_cnt,
  output logic [AW:0]   lifo_cnt,
  output logic [AW:0]   fifo2_cnt,
  output logic [GAW:0]  group_cnt,
  output logic          all_done,
  output logic          err_overflow,
  output logic          err_protocol,
  output logic          err_char
);

  state_e state_q, state_d;

  logic done_thing_q, done_fifo_q, done_lifo_q, done_fifo2_q;
  logic fin_fifo_q, fin_fifo_d;
  logic fin_lifo_q, fin_lifo_d;
  logic fin_fifo2_q, fin_fifo2_d;
  logic err_ovf_q, err_ovf_d;
  logic err_proto_q, err_proto_d;
  logic [7:0] rd_data_q, rd_data_d;

  logic collect;
  logic people_we, lifo_we, fifo2_we, group_we;
  logic people_ovf, lifo_ovf, fifo2_ovf, group_ovf;
  logic lifo_wr_ok;
  logic conflict, late;
  logic [AW:0] lifo_next;
  logic [7:0]  people_rd, lifo_rd, fifo2_rd, group_rd;

  assign collect   = (state_q == ST_COLLECT) & ~clear;
  assign people_we = collect & valid_fifo;
  assign lifo_we   = collect & valid_lifo & ~valid_fifo2;
  assign fifo2_we  = collect & valid_fifo2 & ~valid_lifo;
  assign group_we  = collect & done_thing & ~done_thing_q;
  assign conflict  = collect & valid_lifo & valid_fifo2;
  assign late      = collect & ((valid_fifo  & fin_fifo_q) |
                                (valid_lifo  & fin_lifo_q) |
                                (valid_fifo2 & fin_fifo2_q));

  // A boundary in the same cycle as a LIFO beat records the post-write count.
  assign lifo_wr_ok = lifo_we & ~lifo_ovf;
  assign lifo_next  = lifo_cnt + (AW+1)'(lifo_wr_ok);

  cipu_byte_buf #(.DEPTH(DEPTH), .AW(AW)) u_people (
    .clk(clk), .rst(rst), .clr_i(clear), .we_i(people_we),
    .wdata_i(people_thing_out), .rd_addr_i(rd_addr), .rd_data_o(people_rd),
    .cnt_o(people_cnt), .ovf_o(people_ovf)
  );

  cipu_byte_buf #(.DEPTH(DEPTH), .AW(AW)) u_lifo (
    .clk(clk), .rst(rst), .clr_i(clear), .we_i(lifo_we),
    .wdata_i(thing_out), .rd_addr_i(rd_addr), .rd_data_o(lifo_rd),
    .cnt_o(lifo_cnt), .ovf_o(lifo_ovf)
  );

  cipu_byte_buf #(.DEPTH(DEPTH), .AW(AW)) u_fifo2 (
    .clk(clk), .rst(rst), .clr_i(clear), .we_i(fifo2_we),
    .wdata_i(thing_out), .rd_addr_i(rd_addr), .rd_data_o(fifo2_rd),
    .cnt_o(fifo2_cnt), .ovf_o(fifo2_ovf)
  );

  cipu_byte_buf #(.DEPTH(GDEPTH), .AW(GAW)) u_group (
    .clk(clk), .rst(rst), .clr_i(clear), .we_i(group_we),
    .wdata_i(8'(lifo_next)), .rd_addr_i(rd_addr[GAW-1:0]), .rd_data_o(group_rd),
    .cnt_o(group_cnt), .ovf_o(group_ovf)
  );

  always_comb begin
    state_d     = state_q;
    fin_fifo_d  = fin_fifo_q;
    fin_lifo_d  = fin_lifo_q;
    fin_fifo2_d = fin_fifo2_q;
    err_ovf_d   = err_ovf_q;
    err_proto_d = err_proto_q;
    if (clear) begin
      state_d     = ST_COLLECT;
      fin_fifo_d  = 1'b0;
      fin_lifo_d  = 1'b0;
      fin_fifo2_d = 1'b0;
      err_ovf_d   = 1'b0;
      err_proto_d = 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          fin_fifo_d  = fin_fifo_q  | (done_fifo  & ~done_fifo_q);
          fin_lifo_d  = fin_lifo_q  | (done_lifo  & ~done_lifo_q);
          fin_fifo2_d = fin_fifo2_q | (done_fifo2 & ~done_fifo2_q);
          if (conflict | late) begin
            err_proto_d = 1'b1;
          end
          if (people_ovf | lifo_ovf | fifo2_ovf | group_ovf) begin
            err_ovf_d = 1'b1;
          end
          if (fin_fifo_q & fin_lifo_q & fin_fifo2_q) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_COLLECT;
        end
      endcase
    end
  end

  always_comb begin
    rd_data_d = 8'h00;
    case (rd_sel)
      SEL_PEOPLE: rd_data_d = people_rd;
      SEL_LIFO:   rd_data_d = lifo_rd;
      SEL_FIFO2:  rd_data_d = fifo2_rd;
      default:    rd_data_d = group_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_COLLECT;
      done_thing_q <= 1'b0;
      done_fifo_q  <= 1'b0;
      done_lifo_q  <= 1'b0;
      done_fifo2_q <= 1'b0;
      fin_fifo_q   <= 1'b0;
      fin_lifo_q   <= 1'b0;
      fin_fifo2_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_proto_q  <= 1'b0;
      rd_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      done_thing_q <= done_thing;
      done_fifo_q  <= done_fifo;
      done_lifo_q  <= done_lifo;
      done_fifo2_q <= done_fifo2;
      fin_fifo_q   <= fin_fifo_d;
      fin_lifo_q   <= fin_lifo_d;
      fin_fifo2_q  <= fin_fifo2_d;
      err_ovf_q    <= err_ovf_d;
      err_proto_q  <= err_proto_d;
      rd_data_q    <= rd_data_d;
    end
  end

`ifdef CIPU_COLLECT_CHK_EN
  logic people_wr_ok, fifo2_wr_ok, bad_char;
  logic err_char_q, err_char_d;

  assign people_wr_ok = people_we & ~people_ovf;
  assign fifo2_wr_ok  = fifo2_we & ~fifo2_ovf;
  assign bad_char     = (people_wr_ok & ~is_upper(people_thing_out)) |
                        ((lifo_wr_ok | fifo2_wr_ok) & ~is_digit(thing_out));

  always_comb begin
    err_char_d = err_char_q;
    if (clear) begin
      err_char_d = 1'b0;
    end else if (bad_char) begin
      err_char_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_char_q <= 1'b0;
    end else begin
      err_char_q <= err_char_d;
    end
  end

  assign err_char = err_char_q;
`else
  assign err_char = 1'b0;
`endif

  assign rd_data      = rd_data_q;
  assign all_done     = (state_q == ST_DONE);
  assign err_overflow = err_ovf_q;
  assign err_protocol = err_proto_q;

endmodule

`default_nettype wire

// File: tb/tb_cipu_out_collector.sv
//------------------------------------------------------------------------------
// Module   : tb_cipu_out_collector
// Purpose  : Scoreboard bench for cipu_out_collector (directed vectors).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cipu_out_collector;

  localparam logic [3:0] S_PEOPLE = 4'd0;
  localparam logic [3:0] S_LIFO   = 4'd1;
  localparam logic [3:0] S_FIFO2  = 4'd2;
  localparam logic [3:0] S_GROUP  = 4'd3;
  localparam logic [3:0] S_ALLD   = 4'd4;
  localparam logic [3:0] S_ERRO   = 4'd5;
  localparam logic [3:0] S_ERRP   = 4'd6;
  localparam logic [3:0] S_ERRC   = 4'd7;
  localparam logic [3:0] S_RD     = 4'd8;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  sig;
    logic [7:0]  val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_fifo = 1'b0, valid_lifo = 1'b0, valid_fifo2 = 1'b0;
  logic [7:0] people_thing_out = 8'h00, thing_out = 8'h00;
  logic       done_thing = 1'b0, done_fifo = 1'b0, done_lifo = 1'b0, done_fifo2 = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] rd_sel = 2'd0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [5:0] people_cnt, lifo_cnt, fifo2_cnt;
  logic [4:0] group_cnt;
  logic       all_done, err_overflow, err_protocol, err_char;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  cipu_out_collector dut (
    .clk(clk), .rst(rst),
    .valid_fifo(valid_fifo), .valid_lifo(valid_lifo), .valid_fifo2(valid_fifo2),
    .people_thing_out(people_thing_out), .thing_out(thing_out),
    .done_thing(done_thing), .done_fifo(done_fifo), .done_lifo(done_lifo),
    .done_fifo2(done_fifo2), .clear(clear), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_data(rd_data), .people_cnt(people_cnt), .lifo_cnt(lifo_cnt),
    .fifo2_cnt(fifo2_cnt), .group_cnt(group_cnt), .all_done(all_done),
    .err_overflow(err_overflow), .err_protocol(err_protocol), .err_char(err_char)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] act(input logic [3:0] s);
    case (s)
      S_PEOPLE: return {2'b00, people_cnt};
      S_LIFO:   return {2'b00, lifo_cnt};
      S_FIFO2:  return {2'b00, fifo2_cnt};
      S_GROUP:  return {3'b000, group_cnt};
      S_ALLD:   return {7'd0, all_done};
      S_ERRO:   return {7'd0, err_overflow};
      S_ERRP:   return {7'd0, err_protocol};
      S_ERRC:   return {7'd0, err_char};
      default:  return rd_data;
    endcase
  endfunction

  function automatic string sname(input logic [3:0] s);
    case (s)
      S_PEOPLE: return "people_cnt";
      S_LIFO:   return "lifo_cnt";
      S_FIFO2:  return "fifo2_cnt";
      S_GROUP:  return "group_cnt";
      S_ALLD:   return "all_done";
      S_ERRO:   return "err_overflow";
      S_ERRP:   return "err_protocol";
      S_ERRC:   return "err_char";
      default:  return "rd_data";
    endcase
  endfunction

  // Monitor: pops every expectation due at this cycle and compares.
  always @(negedge clk) begin
    while (sb.size() > 0 && int'(sb[0].cyc) <= cyc) begin
      exp_t e;
      logic [7:0] a;
      e = sb.pop_front();
      a = act(e.sig);
      n_vec++;
      if (int'(e.cyc) != cyc || a !== e.val) begin
        n_err++;
        $display("FAIL %s @cyc %0d (due %0d): got 0x%02h want 0x%02h",
                 sname(e.sig), cyc, e.cyc, a, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lat=0: state visible now; lat=1: after the next edge samples current inputs.
  task automatic expect_v(input logic [3:0] s, input logic [7:0] v, input int lat);
    exp_t e;
    e.cyc = 32'(cyc + lat);
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  initial begin
    step();
    step();
    foreach (sb[i]) ; // queue empty here
    expect_v(S_PEOPLE, 8'd0, 0); expect_v(S_LIFO, 8'd0, 0);
    expect_v(S_FIFO2, 8'd0, 0);  expect_v(S_GROUP, 8'd0, 0);
    expect_v(S_ALLD, 8'd0, 0);   expect_v(S_ERRO, 8'd0, 0);
    expect_v(S_ERRP, 8'd0, 0);   expect_v(S_ERRC, 8'd0, 0);
    expect_v(S_RD, 8'h00, 0);
    rst = 1'b1;

    // People "ABC" and readback
    valid_fifo = 1'b1; people_thing_out = 8'h41; step();
    people_thing_out = 8'h42; step();
    people_thing_out = 8'h43; step();
    valid_fifo = 1'b0; rd_sel = 2'd0; rd_addr = 5'd2;
    expect_v(S_PEOPLE, 8'd3, 0);
    expect_v(S_RD, 8'h43, 1); step();
    rd_addr = 5'd3; expect_v(S_RD, 8'h00, 1); step();

    // Groups: "3","2" | held done_thing | "0" with same-cycle boundary
    valid_lifo = 1'b1; thing_out = 8'h33; step();
    thing_out = 8'h32; step();
    valid_lifo = 1'b0; done_thing = 1'b1; step();
    step();
    expect_v(S_GROUP, 8'd1, 0);
    done_thing = 1'b0; step();
    valid_lifo = 1'b1; thing_out = 8'h30; done_thing = 1'b1;
    expect_v(S_GROUP, 8'd2, 1); expect_v(S_LIFO, 8'd3, 1); step();
    valid_lifo = 1'b0; done_thing = 1'b0;
    rd_sel = 2'd3; rd_addr = 5'd0; expect_v(S_RD, 8'h02, 1); step();
    rd_addr = 5'd1; expect_v(S_RD, 8'h03, 1); step();
    rd_addr = 5'd2; expect_v(S_RD, 8'h00, 1); step();
    rd_sel = 2'd1; rd_addr = 5'd0; expect_v(S_RD, 8'h33, 1); step();

    // FIFO2 beat
    valid_fifo2 = 1'b1; thing_out = 8'h37; step();
    valid_fifo2 = 1'b0; rd_sel = 2'd2; rd_addr = 5'd0;
    expect_v(S_FIFO2, 8'd1, 0);
    expect_v(S_RD, 8'h37, 1); step();

    // Conflict
    expect_v(S_ERRP, 8'd0, 0);
    valid_lifo = 1'b1; valid_fifo2 = 1'b1; thing_out = 8'h35;
    expect_v(S_LIFO, 8'd3, 1); expect_v(S_FIFO2, 8'd1, 1); expect_v(S_ERRP, 8'd1, 1);
    step();
    valid_lifo = 1'b0; valid_fifo2 = 1'b0;

    // Completion, beat in final-edge cycle captured, DONE freezes
    done_lifo = 1'b1; step();
    done_lifo = 1'b0; done_fifo2 = 1'b1; step();
    done_fifo2 = 1'b0; done_fifo = 1'b1; valid_fifo = 1'b1; people_thing_out = 8'h44;
    expect_v(S_ALLD, 8'd0, 1); expect_v(S_PEOPLE, 8'd4, 1); step();
    done_fifo = 1'b0; valid_fifo = 1'b0;
    expect_v(S_ALLD, 8'd1, 1); step();
    valid_fifo = 1'b1; people_thing_out = 8'h45; done_thing = 1'b1;
    valid_lifo = 1'b1; thing_out = 8'h31;
    expect_v(S_PEOPLE, 8'd4, 1); expect_v(S_GROUP, 8'd2, 1);
    expect_v(S_LIFO, 8'd3, 1); expect_v(S_ALLD, 8'd1, 1); expect_v(S_ERRO, 8'd0, 1);
    step();
    valid_fifo = 1'b0; valid_lifo = 1'b0; done_thing = 1'b0;
    rd_sel = 2'd0; rd_addr = 5'd3; expect_v(S_RD, 8'h44, 1); step();

    // Clear beats same-cycle valid and done edge
    clear = 1'b1; valid_fifo = 1'b1; people_thing_out = 8'h41; done_thing = 1'b1;
    expect_v(S_PEOPLE, 8'd0, 1); expect_v(S_LIFO, 8'd0, 1);
    expect_v(S_FIFO2, 8'd0, 1);  expect_v(S_GROUP, 8'd0, 1);
    expect_v(S_ALLD, 8'd0, 1);   expect_v(S_ERRP, 8'd0, 1);
    expect_v(S_ERRO, 8'd0, 1);
    step();
    clear = 1'b0; valid_fifo = 1'b0; done_thing = 1'b0; step();

    // Overflow: 33 people beats into 32 entries
    for (int i = 0; i < 33; i++) begin
      valid_fifo = 1'b1;
      people_thing_out = 8'(8'h41 + (i % 26));
      if (i == 31) begin
        expect_v(S_PEOPLE, 8'd32, 1); expect_v(S_ERRO, 8'd0, 1);
      end
      if (i == 32) begin
        expect_v(S_PEOPLE, 8'd32, 1); expect_v(S_ERRO, 8'd1, 1);
      end
      step();
    end
    valid_fifo = 1'b0; rd_sel = 2'd0; rd_addr = 5'd31;
    expect_v(S_RD, 8'h46, 1); expect_v(S_ERRP, 8'd0, 1); step();

    // Illegal character
    clear = 1'b1; step();
    clear = 1'b0;
    expect_v(S_ERRO, 8'd0, 0);
    valid_fifo = 1'b1; people_thing_out = 8'h61;
    expect_v(S_PEOPLE, 8'd1, 1);
`ifdef CIPU_COLLECT_CHK_EN
    expect_v(S_ERRC, 8'd1, 1);
`else
    expect_v(S_ERRC, 8'd0, 1);
`endif
    step();
    valid_fifo = 1'b0;

    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
